// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: transmitter state encoding, frame-length constants
// and the even-parity helper. The receiver is expected to import this package
// as well, so both ends agree on the frame layout.
//
// Configuration macro: UART_TX_PARITY_EN
//   undefined : 8N1 frame (start, 8 data, stop) = 10 bits
//   defined   : 8E1 frame (start, 8 data, even parity, stop) = 11 bits
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int NUM_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    PARITY_BIT = 3'd4
  } uart_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CYCLES_PER_BIT-1 and raises o_tick during the
// last count of every bit period. The counter wraps to 0 on the tick itself,
// so every bit boundary restarts from zero and no drift can accumulate.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_clear  - hold the counter at 0 (used while the transmitter is idle)
//   o_tick   - high in the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CYCLES_PER_BIT = 217
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign o_tick = (count == LAST_COUNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear || o_tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// -----------------------------------------------------------------------------
// uart_transmit
// UART transmitter, LSB first, idle-high line. A byte is accepted when
// i_tx_valid and o_tx_ready are both high on a rising edge; the start bit
// appears on the line in the next cycle. Each bit lasts CYCLES_PER_BIT cycles.
//
// Configuration macro: UART_TX_PARITY_EN adds an even-parity bit between data
// bit 7 and the stop bit. Without it the frame is plain 8N1.
//
// Ports:
//   i_clk        - clock, rising edge
//   i_rst_n      - asynchronous active-low reset (aborts any frame)
//   i_tx_valid   - a byte is offered
//   i_tx_byte    - byte to send
//   o_tx_ready   - high only in IDLE, byte can be accepted this cycle
//   o_serial_tx  - serial line, registered
//   o_tx_busy    - frame in progress
//   o_tx_done    - one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_serial_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(NUM_DATA_BITS - 1);

  uart_state_t state, state_next;
  logic [7:0]  shift_q, shift_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        serial_q, serial_next;
  logic        done_q, done_next;
  logic        tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_next;
`endif

  // The bit timer is held at zero while idle so the start bit gets a full
  // period measured from the cycle after the transfer.
  uart_baud_tick #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (state == IDLE),
    .o_tick  (tick)
  );

  assign o_tx_ready  = (state == IDLE);
  assign o_tx_busy   = (state != IDLE);
  assign o_serial_tx = serial_q;
  assign o_tx_done   = done_q;

  // State and datapath registers. The line value is computed one cycle ahead
  // so o_serial_tx comes straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_idx  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      shift_q  <= shift_next;
      bit_idx  <= bit_idx_next;
      serial_q <= serial_next;
      done_q   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  // Next-state logic. The shift register is consumed from bit 0: each time a
  // bit period ends, the next line value is shift_q[0] and the register shifts.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_idx_next = bit_idx;
    serial_next  = serial_q;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_q;
`endif

    case (state)
      IDLE: begin
        serial_next = 1'b1;
        if (i_tx_valid) begin
          state_next   = START_BIT;
          serial_next  = 1'b0;
          shift_next   = i_tx_byte;
          bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = even_parity(i_tx_byte);
`endif
        end
      end

      START_BIT: begin
        if (tick) begin
          state_next  = DATA_BITS;
          serial_next = shift_q[0];
          shift_next  = {1'b0, shift_q[7:1]};
        end
      end

      DATA_BITS: begin
        if (tick) begin
          if (bit_idx == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next  = PARITY_BIT;
            serial_next = parity_q;
`else
            state_next  = STOP_BIT;
            serial_next = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            serial_next  = shift_q[0];
            shift_next   = {1'b0, shift_q[7:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (tick) begin
          state_next  = STOP_BIT;
          serial_next = 1'b1;
        end
      end
`endif

      STOP_BIT: begin
        if (tick) begin
          state_next  = IDLE;
          serial_next = 1'b1;
          done_next   = 1'b1;
        end
      end

      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmit.sv
// -----------------------------------------------------------------------------
// tb_uart_transmit
// Self-checking bench for uart_transmit. One instance runs at 4 cycles per bit
// for the directed frame tests, a second at 217 cycles per bit for bit-length
// measurement over four back-to-back frames. Expected line values come from a
// frame model built from the byte sent; a mid-bit sampler decodes each frame.
// Honours UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_transmit;
  import uart_pkg::*;

  localparam int CPB      = 4;
  localparam int SLOW_CPB = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready, serial_tx, tx_busy, tx_done;

  logic       valid_s;
  logic [7:0] byte_s;
  logic       ready_s, serial_s, busy_s, done_s;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_transmit #(.CYCLES_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tx_valid  (tx_valid),
    .i_tx_byte   (tx_byte),
    .o_tx_ready  (tx_ready),
    .o_serial_tx (serial_tx),
    .o_tx_busy   (tx_busy),
    .o_tx_done   (tx_done)
  );

  uart_transmit #(.CYCLES_PER_BIT(SLOW_CPB)) dut_slow (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tx_valid  (valid_s),
    .i_tx_byte   (byte_s),
    .o_tx_ready  (ready_s),
    .o_serial_tx (serial_s),
    .o_tx_busy   (busy_s),
    .o_tx_done   (done_s)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference frame: bit 0 is the start bit, then data LSB first,
  // optional even parity, then the stop bit.
  function automatic logic [FRAME_BITS-1:0] frameBits(input logic [7:0] b);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[FRAME_BITS-1] = 1'b1;
    return f;
  endfunction

  // Offer a byte from a point just after a rising edge; returns just after
  // the transfer edge, i.e. in the first start-bit cycle.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_ready) checkOutput("ready_timeout", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Check every cycle of a frame against the model, starting in the first
  // start-bit cycle and ending in the last stop-bit cycle. With noise set,
  // i_tx_valid is held high with a changing byte until the final cycle.
  task automatic checkFrame(input string tag, input logic [7:0] b, input bit noise);
    logic [FRAME_BITS-1:0] bits;
    logic [7:0]            rx;
    bit                    last;
    bits = frameBits(b);
    rx   = '0;
    for (int j = 0; j < FRAME_BITS; j++) begin
      for (int c = 0; c < CPB; c++) begin
        checkOutput({tag, "_serial"}, {31'd0, serial_tx}, {31'd0, bits[j]});
        checkOutput({tag, "_busy_ready_done"}, {29'd0, tx_busy, tx_ready, tx_done}, 32'h4);
        if (c == CPB / 2 && j >= 1 && j <= 8) rx[j-1] = serial_tx;
        last = (j == FRAME_BITS - 1) && (c == CPB - 1);
        if (noise) begin
          tx_valid = !last;
          tx_byte  = 8'($urandom);
        end
        if (!last) begin
          @(posedge clk); #1;
        end
      end
    end
    checkOutput({tag, "_rx_byte"}, {24'd0, rx}, {24'd0, b});
  endtask

  // Move into the cycle right after the frame: done pulse, ready, line idle.
  task automatic checkDoneCycle(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_done_cycle"}, {28'd0, tx_done, tx_ready, tx_busy, serial_tx}, 32'hD);
  endtask

  // Measure run lengths of equal line values on the slow instance; a run of
  // n identical bits must last exactly n*SLOW_CPB cycles. The stop run ends
  // at the done pulse.
  task automatic measureSlowFrame(input logic [7:0] b);
    logic [FRAME_BITS-1:0] bits;
    int j, len, cnt;
    logic v;
    bits = frameBits(b);
    checkOutput("slow_busy", {31'd0, busy_s}, 32'd1);
    j = 0;
    while (j < FRAME_BITS) begin
      v   = bits[j];
      len = 0;
      while (j < FRAME_BITS && bits[j] == v) begin
        len++;
        j++;
      end
      cnt = 0;
      while (serial_s == v && cnt < 12 * SLOW_CPB && !done_s) begin
        cnt++;
        @(posedge clk); #1;
      end
      checkOutput("slow_run_length", cnt, len * SLOW_CPB);
    end
    checkOutput("slow_done", {31'd0, done_s}, 32'd1);
  endtask

  initial begin
    automatic logic [7:0] slow_bytes [4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    valid_s  = 1'b0;
    byte_s   = 8'h00;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {28'd0, serial_tx, tx_ready, tx_busy, tx_done}, 32'hC);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_after_reset", {28'd0, serial_tx, tx_ready, tx_busy, tx_done}, 32'hC);

    // 0x55: alternating line, done in cycle 41 after transfer, then drops.
    applyStimulus(8'h55);
    checkFrame("f55", 8'h55, 1'b0);
    checkDoneCycle("f55");
    @(posedge clk); #1;
    checkOutput("f55_done_one_cycle", {31'd0, tx_done}, 32'd0);

    // 0xA3 then 0x0F offered in the done cycle: single idle-high gap.
    applyStimulus(8'hA3);
    checkFrame("fA3", 8'hA3, 1'b0);
    checkDoneCycle("fA3");
    tx_valid = 1'b1;
    tx_byte  = 8'h0F;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    checkFrame("f0F", 8'h0F, 1'b0);
    checkDoneCycle("f0F");

    // Valid held high with a changing byte during the frame.
    applyStimulus(8'h3C);
    checkFrame("f3C_noise", 8'h3C, 1'b1);
    checkDoneCycle("f3C_noise");
    @(posedge clk); #1;
    checkOutput("no_queued_frame", {30'd0, tx_busy, serial_tx}, 32'h1);

    // Reset in the middle of data bit 3 (0xF7 has bit 3 low).
    applyStimulus(8'hF7);
    repeat (4 * CPB + 1) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_bit3_line", {31'd0, serial_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_abort", {28'd0, serial_tx, tx_ready, tx_busy, tx_done}, 32'hC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", {29'd0, tx_done, tx_busy, serial_tx}, 32'h1);
    end
    applyStimulus(8'h81);
    checkFrame("f81", 8'h81, 1'b0);
    checkDoneCycle("f81");

`ifdef UART_TX_PARITY_EN
    applyStimulus(8'h07);
    checkFrame("par07", 8'h07, 1'b0);
    checkDoneCycle("par07");
    applyStimulus(8'h03);
    checkFrame("par03", 8'h03, 1'b0);
    checkDoneCycle("par03");
`endif

    // Slow instance: four consecutive frames, each next byte on the done cycle.
    checkOutput("slow_ready", {31'd0, ready_s}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      valid_s = 1'b1;
      byte_s  = slow_bytes[k];
      @(posedge clk); #1;
      valid_s = 1'b0;
      measureSlowFrame(slow_bytes[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
